// File: rtl/tt_sweep_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_pkg
// Shared types and constants for the truth-table sweep controller.
//   state_t : sweep FSM states
//   N_IN    : number of inputs of the gate under test
//   TT_W    : truth table width (2**N_IN)
//   idx_t   : input vector index
// ---------------------------------------------------------------------------
package tt_sweep_pkg;

  localparam int N_IN = 4;
  localparam int TT_W = 1 << N_IN;

  typedef logic [N_IN-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage : tt_sweep_pkg

// File: rtl/tt_settle_timer.sv
// ---------------------------------------------------------------------------
// tt_settle_timer
// Counts the settle time of one input vector. A load arms the counter with
// SETTLE_CYCLES-1; while enabled it counts down and o_expire is high in the
// last enabled cycle, so the enable window lasts exactly SETTLE_CYCLES cycles.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   i_load   : (re)arm the counter
//   i_en     : counting window (DRIVE state)
//   o_expire : final settle cycle of the current window
// ---------------------------------------------------------------------------
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] r_cnt;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == 4'd0);

endmodule : tt_settle_timer

// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
// Exhaustively drives all 16 input vectors into a combinational gate, samples
// its output after a settle time and compares the captured truth table with a
// golden one latched at start.
// Ports:
//   clk, rst      : clock / asynchronous active-high reset
//   start         : begin a sweep (IDLE only; beats abort in the same cycle)
//   abort         : cancel a sweep in DRIVE/SAMPLE, no done pulse
//   expected_tt   : golden truth table, latched at accept
//   func_out      : output of the gate under test
//   func_in       : vector driven to the gate (holds last value when idle)
//   busy          : sweep in progress
//   done          : one-cycle completion pulse
//   pass          : captured == expected, held until the next accepted start
//   captured_tt   : sampled gate outputs
//   mismatch_mask : sampled bits that differ from the golden table
// Build option:
//   TT_SWEEP_FIRST_FAIL_EN : end the sweep at the first mismatching vector.
// ---------------------------------------------------------------------------
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int N_IN          = tt_sweep_pkg::N_IN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [tt_sweep_pkg::TT_W-1:0] expected_tt,
  input  logic                          func_out,
  output logic [N_IN-1:0]               func_in,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [tt_sweep_pkg::TT_W-1:0] captured_tt,
  output logic [tt_sweep_pkg::TT_W-1:0] mismatch_mask
);

  import tt_sweep_pkg::*;

  state_t          r_state;
  state_t          w_next;
  idx_t            r_idx;
  logic [TT_W-1:0] r_exp;
  logic [TT_W-1:0] r_cap;
  logic [TT_W-1:0] r_mm;
  logic            r_done;
  logic            r_pass;

  logic w_expire;
  logic w_load;
  logic w_miss;
  logic w_stop;

  assign w_miss = func_out ^ r_exp[r_idx];

`ifdef TT_SWEEP_FIRST_FAIL_EN
  assign w_stop = (r_idx == idx_t'(TT_W - 1)) || w_miss;
`else
  assign w_stop = (r_idx == idx_t'(TT_W - 1));
`endif

  // Arm the settle timer on every entry into DRIVE.
  assign w_load = ((r_state == ST_IDLE) && start) ||
                  ((r_state == ST_SAMPLE) && !abort && !w_stop);

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_en    (r_state == ST_DRIVE),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_DRIVE;
      ST_DRIVE: begin
        if (abort)         w_next = ST_IDLE;
        else if (w_expire) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)       w_next = ST_IDLE;
        else if (w_stop) w_next = ST_DONE;
        else             w_next = ST_DRIVE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // pass is cleared at accept, so an aborted sweep leaves it at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_exp  <= '0;
      r_cap  <= '0;
      r_mm   <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_exp  <= expected_tt;
            r_cap  <= '0;
            r_mm   <= '0;
            r_idx  <= '0;
            r_pass <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (!abort) begin
            r_cap[r_idx] <= func_out;
            r_mm[r_idx]  <= w_miss;
            if (!w_stop) r_idx <= r_idx + idx_t'(1);
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_cap == r_exp);
        end
        default: ;
      endcase
    end
  end

  assign func_in       = r_idx;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign pass          = r_pass;
  assign captured_tt   = r_cap;
  assign mismatch_mask = r_mm;

endmodule : tt_sweep_ctrl

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
// Two controller instances (SETTLE_CYCLES = 1 and 4) each drive their own
// gate model. Sweep expectations come from a behavioural model, are pushed to
// a scoreboard queue when start is driven and popped when done appears.
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

  typedef struct {
    int          lat;
    logic        pass;
    logic [15:0] cap;
    logic [15:0] mm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4, abort;
  logic [15:0] expected_tt;
  logic [15:0] gate_tt;

  logic [3:0]  func_in1, func_in4;
  logic        func_out1, func_out4;
  logic        busy1, done1, pass1, busy4, done4, pass4;
  logic [15:0] cap1, mm1, cap4, mm4;

  logic        sel4;
  logic [3:0]  s_func_in;
  logic        s_busy, s_done, s_pass;
  logic [15:0] s_cap, s_mm;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  assign func_out1 = gate_tt[func_in1];
  assign func_out4 = gate_tt[func_in4];

  assign s_func_in = sel4 ? func_in4 : func_in1;
  assign s_busy    = sel4 ? busy4    : busy1;
  assign s_done    = sel4 ? done4    : done1;
  assign s_pass    = sel4 ? pass4    : pass1;
  assign s_cap     = sel4 ? cap4     : cap1;
  assign s_mm      = sel4 ? mm4      : mm1;

  tt_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .expected_tt(expected_tt), .func_out(func_out1), .func_in(func_in1),
    .busy(busy1), .done(done1), .pass(pass1),
    .captured_tt(cap1), .mismatch_mask(mm1)
  );

  tt_sweep_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort),
    .expected_tt(expected_tt), .func_out(func_out4), .func_in(func_in4),
    .busy(busy4), .done(done4), .pass(pass4),
    .captured_tt(cap4), .mismatch_mask(mm4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [15:0] gate, input logic [15:0] tt, input int s);
    exp_t m;
    m.cap = '0;
    m.mm  = '0;
    m.lat = 16 * (s + 1) + 1;
    for (int i = 0; i < 16; i++) begin
      m.cap[i] = gate[i];
      m.mm[i]  = gate[i] ^ tt[i];
`ifdef TT_SWEEP_FIRST_FAIL_EN
      if (m.mm[i]) begin
        m.lat = (i + 1) * (s + 1) + 1;
        break;
      end
`endif
    end
    m.pass = (m.mm == 16'h0000);
    return m;
  endfunction

  // One sweep: optional abort alongside start (start must win) and optional
  // stray start pulse mid-sweep (must be ignored).
  task automatic sweep(input bit use4, input logic [15:0] tt, input int mid_start,
                       input bit abort_with_start);
    exp_t e;
    int   cyc;
    sel4 = use4;
    sb_q.push_back(model(gate_tt, tt, use4 ? 4 : 1));
    @(negedge clk);
    expected_tt = tt;
    abort       = abort_with_start;
    if (use4) start4 = 1'b1;
    else      start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    abort  = 1'b0;
    expected_tt = ~tt;
    check("busy_after_accept", s_busy, 1);
    cyc = 0;
    while (!s_done && cyc < 200) begin
      if (use4 && cyc < 80) check("func_in_settle", s_func_in, cyc / 5);
      if (!use4) start1 = (cyc == mid_start);
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0;
    check("done_seen", s_done, 1);
    e = sb_q.pop_front();
    check("done_latency", cyc, e.lat);
    check("pass", s_pass, e.pass);
    check("captured_tt", s_cap, e.cap);
    check("mismatch_mask", s_mm, e.mm);
    check("busy_at_done", s_busy, 0);
    @(negedge clk);
    check("done_one_cycle", s_done, 0);
    check("pass_held", s_pass, e.pass);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
    expected_tt = '0; gate_tt = 16'hBDF1; sel4 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_cap", cap1, 0);
    check("rst_mm", mm1, 0);
    check("rst_func_in", func_in1, 0);
    rst = 1'b0;

    // Matching golden table, then a single-bit mismatch.
    sweep(1'b0, 16'hBDF1, -1, 1'b0);
    check("func_in_hold_idle", func_in1, 15);
    sweep(1'b0, 16'hBDF0, -1, 1'b0);
    // Stray start at vector 3; abort coincident with start in IDLE.
    sweep(1'b0, 16'hBDF1, 6, 1'b0);
    sweep(1'b0, 16'h1234, -1, 1'b1);

    // Abort during the SAMPLE of vector 5.
    @(negedge clk);
    expected_tt = 16'hBDF1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (11) @(negedge clk);
    check("abort_at_vec5", func_in1, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_pass", pass1, 0);
    check("abort_cap", cap1, 16'h0011);
    check("abort_mm", mm1, 16'h0000);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    expected_tt = 16'hBDF1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_cap", cap1, 16'h0011);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy1, 0);
    check("arst_done", done1, 0);
    check("arst_cap", cap1, 0);
    check("arst_mm", mm1, 0);
    check("arst_func_in", func_in1, 0);
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0, 16'hBDF1, -1, 1'b0);

    // Longer settle time on the second instance.
    gate_tt = 16'h6A5C;
    sweep(1'b1, 16'h6A5C, -1, 1'b0);
    sweep(1'b1, 16'h6A1C, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tt_sweep_ctrl
